// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Single-word instruction fetch unit. Walks a program counter through a
//   synchronous-read instruction memory and presents one instruction word at a
//   time to a consumer through a valid/ready handshake. A redirect input
//   reloads the program counter and flushes any held or in-flight word.
//
//   Fetch sequence: IDLE -> REQ (memory enable) -> CAPT (memory data valid,
//   word captured) -> HOLD (word offered until the consumer takes it).
//
// Ports:
//   i_clk            clock, all state changes on its rising edge
//   i_rst            synchronous active-high reset
//   i_run            fetch enable; no new fetch is started while low
//   i_redirect       load the PC from i_redirect_addr and flush
//   i_redirect_addr  redirect target
//   o_mem_en         instruction memory enable (high only in REQ)
//   o_mem_we         instruction memory write enable, always 0
//   o_mem_addr       instruction memory address, always equal to the PC
//   o_mem_di         instruction memory write data, always 0
//   i_mem_do         instruction memory read data, valid the cycle after
//                    o_mem_en is sampled high
//   o_ir             held instruction word
//   o_ir_pc          address the held word was fetched from
//   o_ir_valid       o_ir holds a word not yet consumed
//   i_ir_ready       consumer accepts o_ir at this edge
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned addWidth  = 6,
   parameter int unsigned dataWidth = 16,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_run,
   input  logic                 i_redirect,
   input  logic [addWidth-1:0]  i_redirect_addr,
   output logic                 o_mem_en,
   output logic                 o_mem_we,
   output logic [addWidth-1:0]  o_mem_addr,
   output logic [dataWidth-1:0] o_mem_di,
   input  logic [dataWidth-1:0] i_mem_do,
   output logic [dataWidth-1:0] o_ir,
   output logic [addWidth-1:0]  o_ir_pc,
   output logic                 o_ir_valid,
   input  logic                 i_ir_ready
);

   localparam logic [addWidth-1:0] ResetPc = addWidth'(RESET_PC);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StCapt = 2'd2,
      StHold = 2'd3
   } state_e;

   state_e                 r_state;
   state_e                 w_state_d;
   logic [addWidth-1:0]    r_pc;
   logic [addWidth-1:0]    w_pc_d;
   logic [dataWidth-1:0]   r_ir;
   logic [dataWidth-1:0]   w_ir_d;
   logic [addWidth-1:0]    r_ir_pc;
   logic [addWidth-1:0]    w_ir_pc_d;
   logic                   r_ir_valid;
   logic                   w_ir_valid_d;
   logic                   w_transfer;

   assign w_transfer = r_ir_valid & i_ir_ready;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_pc       <= ResetPc;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_ir       <= w_ir_d;
         r_ir_pc    <= w_ir_pc_d;
         r_ir_valid <= w_ir_valid_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d    = r_state;
      w_pc_d       = r_pc;
      w_ir_d       = r_ir;
      w_ir_pc_d    = r_ir_pc;
      w_ir_valid_d = r_ir_valid;

      if (i_redirect) begin
         // Redirect wins over capture and over a handshake: the held or
         // in-flight word is dropped and fetching restarts at the target.
         w_pc_d       = i_redirect_addr;
         w_ir_valid_d = 1'b0;
         w_state_d    = i_run ? StReq : StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_run) begin
                  w_state_d = StReq;
               end
            end
            // Memory samples o_mem_addr at this edge; run is not checked so
            // a started fetch always completes.
            StReq: begin
               w_state_d = StCapt;
            end
            StCapt: begin
               w_ir_d       = i_mem_do;
               w_ir_pc_d    = r_pc;
               w_ir_valid_d = 1'b1;
               w_pc_d       = r_pc + 1'b1;  // wraps at 2**addWidth
               w_state_d    = StHold;
            end
            StHold: begin
               if (w_transfer) begin
                  w_ir_valid_d = 1'b0;
                  w_state_d    = i_run ? StReq : StIdle;
               end
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   // Memory port is decoded purely from registered state
   always_comb begin
      o_mem_en   = (r_state == StReq);
      o_mem_addr = r_pc;
   end

   assign o_mem_we   = 1'b0;
   assign o_mem_di   = '0;
   assign o_ir       = r_ir;
   assign o_ir_pc    = r_ir_pc;
   assign o_ir_valid = r_ir_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed testbench for instr_fetch. A behavioural synchronous-read memory
// holds 16'hA000 + address at every location. Inputs change 1 ns after a
// rising edge; outputs are checked at the same point, reflecting the state
// produced by that edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;

   logic          clk;
   logic          rst;
   logic          run;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_di;
   logic [DW-1:0] mem_do;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready;

   logic [DW-1:0] mem [64];

   int passes = 0;
   int total  = 0;

   instr_fetch #(
      .addWidth (AW),
      .dataWidth(DW),
      .RESET_PC (0)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_run          (run),
      .i_redirect     (redirect),
      .i_redirect_addr(redirect_addr),
      .o_mem_en       (mem_en),
      .o_mem_we       (mem_we),
      .o_mem_addr     (mem_addr),
      .o_mem_di       (mem_di),
      .i_mem_do       (mem_do),
      .o_ir           (ir),
      .o_ir_pc        (ir_pc),
      .o_ir_valid     (ir_valid),
      .i_ir_ready     (ir_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory
   always @(posedge clk) begin
      if (mem_en) mem_do <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Check a delivered word in HOLD
   task automatic chk_word(input string tag, input logic [AW-1:0] pc);
      logic [DW-1:0] exp_word;
      exp_word = 16'hA000 + DW'(pc);
      chk({tag, "_valid"}, 32'(ir_valid), 32'd1);
      chk({tag, "_ir"}, 32'(ir), 32'(exp_word));
      chk({tag, "_pc"}, 32'(ir_pc), 32'(pc));
   endtask

   // REQ then CAPT with no valid word, then the delivered word
   task automatic fetch_cycle(input string tag, input logic [AW-1:0] pc);
      tick();
      chk({tag, "_req_en"}, 32'(mem_en), 32'd1);
      chk({tag, "_req_addr"}, 32'(mem_addr), 32'(pc));
      chk({tag, "_req_nv"}, 32'(ir_valid), 32'd0);
      tick();
      chk({tag, "_capt_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_capt_nv"}, 32'(ir_valid), 32'd0);
      tick();
      chk_word(tag, pc);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
      mem_do        = '0;
      rst           = 1'b1;
      run           = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      ir_ready      = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(ir_valid), 32'd0);
      chk("rst_ir", 32'(ir), 32'd0);
      chk("rst_irpc", 32'(ir_pc), 32'd0);
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_di", 32'(mem_di), 32'd0);

      // Streaming: first word 3 edges after release, then one per 3 cycles
      rst = 1'b0;
      run = 1'b1;
      fetch_cycle("s0", 6'd0);
      fetch_cycle("s1", 6'd1);

      // Backpressure while A001 is held
      ir_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_word("bp", 6'd1);
         chk("bp_en", 32'(mem_en), 32'd0);
      end
      ir_ready = 1'b1;
      fetch_cycle("s2", 6'd2);
      fetch_cycle("s3", 6'd3);

      // Wrap: redirect to 62 while A003 is being accepted
      redirect      = 1'b1;
      redirect_addr = 6'd62;
      tick();
      redirect = 1'b0;
      chk("wr_req_en", 32'(mem_en), 32'd1);
      chk("wr_req_addr", 32'(mem_addr), 32'd62);
      chk("wr_req_nv", 32'(ir_valid), 32'd0);
      tick();
      tick();
      chk_word("w62", 6'd62);
      fetch_cycle("w63", 6'd63);
      fetch_cycle("w0", 6'd0);
      chk("w0_nextpc", 32'(mem_addr), 32'd1);

      // Redirect to 5, then redirect to 10 during the CAPT of address 5
      redirect      = 1'b1;
      redirect_addr = 6'd5;
      tick();
      redirect = 1'b0;
      chk("r5_addr", 32'(mem_addr), 32'd5);
      tick();
      chk("r5_capt_addr", 32'(mem_addr), 32'd5);
      chk("r5_capt_en", 32'(mem_en), 32'd0);
      redirect      = 1'b1;
      redirect_addr = 6'd10;
      tick();
      redirect = 1'b0;
      chk("r10_nv", 32'(ir_valid), 32'd0);
      chk("r10_en", 32'(mem_en), 32'd1);
      chk("r10_addr", 32'(mem_addr), 32'd10);
      tick();
      chk("r10_capt_nv", 32'(ir_valid), 32'd0);
      tick();
      chk_word("r10", 6'd10);

      // Run drop during REQ: fetch of 11 completes, then IDLE
      tick();
      chk("rd_req_en", 32'(mem_en), 32'd1);
      chk("rd_req_addr", 32'(mem_addr), 32'd11);
      run = 1'b0;
      tick();
      chk("rd_capt_nv", 32'(ir_valid), 32'd0);
      tick();
      chk_word("rd11", 6'd11);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rd_idle_en", 32'(mem_en), 32'd0);
         chk("rd_idle_nv", 32'(ir_valid), 32'd0);
         chk("rd_idle_addr", 32'(mem_addr), 32'd12);
      end
      run = 1'b1;
      tick();
      chk("rd_resume_en", 32'(mem_en), 32'd1);
      chk("rd_resume_addr", 32'(mem_addr), 32'd12);

      // Reset during CAPT of 12
      tick();
      chk("mr_capt_en", 32'(mem_en), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_nv", 32'(ir_valid), 32'd0);
      chk("mr_ir", 32'(ir), 32'd0);
      chk("mr_irpc", 32'(ir_pc), 32'd0);
      chk("mr_pc", 32'(mem_addr), 32'd0);
      chk("mr_en", 32'(mem_en), 32'd0);
      fetch_cycle("mr0", 6'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter addWidth, default 6, meaning the instruction memory address width (64 words).
REQ-002 The module SHALL have parameter dataWidth, default 16, meaning the instruction word width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the program counter value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 run  input  1  fetch enable; while low, no new fetch is issued.
REQ-007 redirect  input  1  branch/jump request; load the PC from redirect_addr.
REQ-008 redirect_addr  input  addWidth  redirect target address.
REQ-009 mem_en  output  1  instruction memory enable.
REQ-010 mem_we  output  1  instruction memory write enable; tied to 0.
REQ-011 mem_addr  output  addWidth  instruction memory address.
REQ-012 mem_di  output  dataWidth  instruction memory write data; tied to 0.
REQ-013 mem_do  input  dataWidth  instruction memory read data, valid in the cycle after mem_en is sampled high.
REQ-014 ir  output  dataWidth  held instruction word.
REQ-015 ir_pc  output  addWidth  address from which ir was fetched.
REQ-016 ir_valid  output  1  ir holds an instruction not yet consumed.
REQ-017 ir_ready  input  1  consumer accepts ir at this edge.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, CAPT and HOLD, with state and pc held in registers.
REQ-019 mem_en SHALL be 1 only in REQ, and mem_addr SHALL equal pc at all times; both are decoded from registered state only.
REQ-020 IDLE SHALL go to REQ when run=1, and SHALL otherwise stay in IDLE.
REQ-021 REQ SHALL always go to CAPT; the memory registers the word for pc at this edge.
REQ-022 At the edge leaving CAPT, the block SHALL load ir with mem_do, load ir_pc with pc, set ir_valid to 1, set pc to pc+1, and go to HOLD.
REQ-023 A transfer SHALL occur at an edge where ir_valid=1 and ir_ready=1.
REQ-024 In HOLD, on a transfer the block SHALL clear ir_valid and go to REQ if run=1, or to IDLE if run=0.
REQ-025 In HOLD without a transfer, ir, ir_pc and ir_valid SHALL remain stable.
REQ-026 Steady-state throughput SHALL be one instruction per 3 cycles; latency from entering REQ to ir_valid=1 SHALL be 2 cycles.
REQ-027 pc increment SHALL wrap modulo 2**addWidth (63 -> 0 at default width).
REQ-028 run falling while in REQ or CAPT SHALL NOT abort the fetch; the fetch completes into HOLD, and the next transition follows REQ-024.
REQ-029 When redirect=1 at an edge, the block SHALL load pc with redirect_addr and clear ir_valid, discarding any held or in-flight word; the next state SHALL be REQ if run=1, else IDLE.
REQ-030 Redirect SHALL take priority over a simultaneous transfer and over CAPT capture; that capture is suppressed and the transfer is treated as not occurring.
REQ-031 mem_we and mem_di SHALL be constant 0; the block never writes memory.

Reset
REQ-032 rst=1 at an edge SHALL force state to IDLE, pc to RESET_PC, ir to 0, ir_pc to 0 and ir_valid to 0, regardless of state, redirect or run.
REQ-033 Reset mid-fetch (in REQ or CAPT) SHALL discard the fetch; no ir_valid pulse may follow.
REQ-034 During rst=1 and in the cycle after, mem_en SHALL be 0.

Verification
REQ-035 The bench SHALL preload memory words 0..3 with 16'hA000..16'hA003, hold run=1 and ir_ready=1 -> ir sequence A000, A001, A002, A003 with ir_pc 0..3, ir_valid asserted every 3rd cycle, and first ir_valid 3 cycles after reset release.
REQ-036 The bench SHALL check backpressure: ir_ready=0 for 5 cycles while ir=A001 -> ir, ir_pc and ir_valid stable, mem_en=0 throughout; after ir_ready=1, the next word A002 appears.
REQ-037 The bench SHALL check wrap: redirect to 62 with words 62, 63 and 0 distinct -> ir_pc sequence 62, 63, 0.
REQ-038 The bench SHALL check redirect: redirect=1 with target 10 in the same cycle as the CAPT of address 5 -> word 5 is never presented, and the next ir_pc is 10.
REQ-039 The bench SHALL check run drop: run=0 asserted during REQ -> that fetch is delivered, then the FSM goes to IDLE after the transfer and mem_en stays 0 until run=1.
REQ-040 The bench SHALL check reset mid-operation: rst=1 during CAPT -> the next cycle has ir_valid=0, ir=0 and pc=RESET_PC, and the first fetch after release uses address 0.
